// File: rtl/mhd_pkg.sv
// Shared definitions for the Hamming-distance monitor and the miter flow:
// result-width helper, a widest-case hd typedef and the error predicate.
package mhd_pkg;

  // Widest operand the monitor is meant to handle.
  localparam int MAX_WIDTH = 64;

  // Bits needed to hold a popcount of a w-bit vector (0..w inclusive).
  function automatic int hd_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int HD_MAX_W = $clog2(MAX_WIDTH + 1);

  // Container wide enough for any hd produced by a legal WIDTH.
  typedef logic [HD_MAX_W-1:0] hd_max_t;

  // Unsigned threshold test: a sample is in error when its distance exceeds mhd.
  function automatic logic hd_exceeds(input int unsigned hd_val, input int unsigned mhd);
    return hd_val > mhd;
  endfunction

endpackage

// File: rtl/mhd_popcount.sv
// Combinational popcount of a WIDTH-bit vector; result is exact at HD_W bits.
module mhd_popcount
  import mhd_pkg::*;
#(
  parameter  int WIDTH = 16,
  localparam int HD_W  = hd_width(WIDTH)
) (
  input  logic [WIDTH-1:0] x,
  output logic [HD_W-1:0]  count
);

  // Ripple sum of the set bits; HD_W always covers the maximum value WIDTH.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + HD_W'(x[i]);
    end
  end

endmodule

// File: rtl/mhd_monitor.sv
// Hamming-distance monitor between an exact and an approximate operand.
// Two-stage pipeline (S1: a^b, S2: hd/err) with valid/ready handshakes on
// both sides, saturating sample/error counters and an optional max-hd
// register built only when MHD_MONITOR_MAXHD_EN is defined.
module mhd_monitor
  import mhd_pkg::*;
#(
  parameter  int          WIDTH = 16,
  parameter  int unsigned MHD   = 5,
  parameter  int          CNT_W = 32,
  localparam int          HD_W  = hd_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [HD_W-1:0]  hd,
  output logic             err,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [HD_W-1:0]  max_hd
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic             s2_valid_q, s2_valid_d;
  logic [HD_W-1:0]  s2_hd_q, s2_hd_d;
  logic             s2_err_q, s2_err_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic [HD_W-1:0]  pc_hd;
  logic             pc_err;
  logic             s2_ready;
  logic             res_acc;

  mhd_popcount #(.WIDTH(WIDTH)) u_popcount (
    .x     (s1_x_q),
    .count (pc_hd)
  );

  // A threshold at or above WIDTH can never be exceeded.
  if (MHD >= WIDTH) begin : g_err_off
    assign pc_err = 1'b0;
  end else begin : g_err_cmp
    assign pc_err = hd_exceeds(32'(pc_hd), MHD);
  end

  // S2 can take new data when empty or when its result leaves this cycle;
  // S1 in turn can take input when empty or when it moves into S2.
  assign s2_ready  = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_ready;
  assign res_acc   = s2_valid_q && out_ready;

  assign out_valid  = s2_valid_q;
  assign hd         = s2_hd_q;
  assign err        = s2_err_q;
  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;

  // Pipeline advance: data registers load only with valid data, so a
  // stalled S2 keeps hd/err stable.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s2_valid_d = s2_valid_q;
    s2_hd_d    = s2_hd_q;
    s2_err_d   = s2_err_q;
    if (s2_ready) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_hd_d  = pc_hd;
        s2_err_d = pc_err;
      end
    end
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_x_d = a ^ b;
      end
    end
  end

  // Saturating statistics; clear beats a result accepted in the same cycle.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    if (clear) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
    end else if (res_acc) begin
      if (sample_cnt_q != '1) begin
        sample_cnt_d = sample_cnt_q + CNT_W'(1);
      end
      if (s2_err_q && (err_cnt_q != '1)) begin
        err_cnt_d = err_cnt_q + CNT_W'(1);
      end
    end
  end

  // State register: reset empties the pipeline and zeroes all statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_x_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_hd_q      <= '0;
      s2_err_q     <= 1'b0;
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_x_q       <= s1_x_d;
      s2_valid_q   <= s2_valid_d;
      s2_hd_q      <= s2_hd_d;
      s2_err_q     <= s2_err_d;
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

`ifdef MHD_MONITOR_MAXHD_EN
  logic [HD_W-1:0] max_hd_q, max_hd_d;

  // Running maximum of accepted distances, zeroed by clear.
  always_comb begin
    max_hd_d = max_hd_q;
    if (clear) begin
      max_hd_d = '0;
    end else if (res_acc && (s2_hd_q > max_hd_q)) begin
      max_hd_d = s2_hd_q;
    end
  end

  // Max register update.
  always_ff @(posedge clk) begin
    if (rst) begin
      max_hd_q <= '0;
    end else begin
      max_hd_q <= max_hd_d;
    end
  end

  assign max_hd = max_hd_q;
`else
  assign max_hd = '0;
`endif

endmodule

// File: tb/tb_mhd_monitor.sv
// Directed self-checking bench for mhd_monitor (WIDTH=16, MHD=5), with a
// second CNT_W=4 instance sharing all inputs to observe counter saturation.
module tb_mhd_monitor;

  localparam int WIDTH = 16;
  localparam int MHD   = 5;
  localparam int HD_W  = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;

  logic             in_ready, out_valid, err;
  logic [HD_W-1:0]  hd, max_hd;
  logic [31:0]      sample_cnt, err_cnt;

  logic             in_ready4, out_valid4, err4;
  logic [HD_W-1:0]  hd4, max_hd4;
  logic [3:0]       sample_cnt4, err_cnt4;

  int n_checks = 0;
  int n_fail   = 0;

  mhd_monitor #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .hd(hd), .err(err),
    .sample_cnt(sample_cnt), .err_cnt(err_cnt), .max_hd(max_hd)
  );

  mhd_monitor #(.WIDTH(WIDTH), .MHD(MHD), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready4), .a(a), .b(b),
    .out_valid(out_valid4), .out_ready(out_ready), .hd(hd4), .err(err4),
    .sample_cnt(sample_cnt4), .err_cnt(err_cnt4), .max_hd(max_hd4)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected max_hd: tracks the real maximum only when the feature is built.
  function automatic logic [HD_W-1:0] exp_max(input logic [HD_W-1:0] v);
`ifdef MHD_MONITOR_MAXHD_EN
    return v;
`else
    return '0;
`endif
  endfunction

  task automatic pulse_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (hd !== 5'd0) begin n_fail++; $display("FAIL reset_hd: got %0d want 0", hd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
    n_checks++; if (sample_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_sample_cnt: got %0d want 0", sample_cnt); end
    n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d want 0", err_cnt); end
    n_checks++; if (max_hd !== 5'd0) begin n_fail++; $display("FAIL reset_max_hd: got %0d want 0", max_hd); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    $display("reset: out_valid=%0b in_ready=%0b sample_cnt=%0d", out_valid, in_ready, sample_cnt);
    rst = 1'b0;
  endtask

  task automatic test_vectors();
    a = 16'h0000; b = 16'h003F; in_valid = 1'b1; out_ready = 1'b1;
    step();
    b = 16'h001F;
    step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL vec1_out_valid: got %0b want 1", out_valid); end
    n_checks++; if (hd !== 5'd6) begin n_fail++; $display("FAIL vec1_hd: got %0d want 6", hd); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL vec1_err: got %0b want 1", err); end
    $display("vector a=0000 b=003f: hd=%0d err=%0b", hd, err);
    in_valid = 1'b0;
    step();
    n_checks++; if (hd !== 5'd5) begin n_fail++; $display("FAIL vec2_hd: got %0d want 5", hd); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL vec2_err: got %0b want 0", err); end
    n_checks++; if (sample_cnt !== 32'd1) begin n_fail++; $display("FAIL vec1_sample_cnt: got %0d want 1", sample_cnt); end
    $display("vector a=0000 b=001f: hd=%0d err=%0b", hd, err);
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vec_drain_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (sample_cnt !== 32'd2) begin n_fail++; $display("FAIL vec_sample_cnt: got %0d want 2", sample_cnt); end
    n_checks++; if (err_cnt !== 32'd1) begin n_fail++; $display("FAIL vec_err_cnt: got %0d want 1", err_cnt); end
    n_checks++; if (max_hd !== exp_max(5'd6)) begin n_fail++; $display("FAIL vec_max_hd: got %0d want %0d", max_hd, exp_max(5'd6)); end
  endtask

  // Full-throughput stream (ready=1) or random stalls on both sides.
  task automatic run_stream(input int n, input bit random_flow, input string tag);
    int exp_hd[$];
    bit exp_err[$];
    int sent = 0, got = 0, errs = 0, iter = 0, h;
    logic [HD_W-1:0] mx = '0;
    bit stalled_prev = 1'b0;
    logic [HD_W-1:0] hd_prev = '0;
    logic err_prev = 1'b0;
    pulse_clear();
    while (got < n && iter < 2000) begin
      if (sent < n) begin
        in_valid = random_flow ? 1'($urandom_range(0, 1)) : 1'b1;
        a = 16'($urandom); b = 16'($urandom);
      end else begin
        in_valid = 1'b0;
      end
      out_ready = random_flow ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (stalled_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || hd !== hd_prev || err !== err_prev) begin
          n_fail++;
          $display("FAIL %s_stall_stable: got v=%0b hd=%0d err=%0b want v=1 hd=%0d err=%0b", tag, out_valid, hd, err, hd_prev, err_prev);
        end
      end
      stalled_prev = out_valid && !out_ready;
      hd_prev = hd; err_prev = err;
      if (in_valid && in_ready) begin
        h = $countones(a ^ b);
        exp_hd.push_back(h); exp_err.push_back(h > MHD);
        if (h > MHD) errs++;
        if (5'(h) > mx) mx = 5'(h);
        sent++;
      end
      if (out_valid && out_ready) begin
        n_checks++;
        if (exp_hd.size() == 0) begin
          n_fail++; $display("FAIL %s_extra_result: got hd=%0d want none", tag, hd);
        end else begin
          if (hd !== 5'(exp_hd[0]) || err !== exp_err[0]) begin
            n_fail++; $display("FAIL %s_result%0d: got hd=%0d err=%0b want hd=%0d err=%0b", tag, got, hd, err, exp_hd[0], exp_err[0]);
          end
          void'(exp_hd.pop_front()); void'(exp_err.pop_front());
        end
        $display("%s result %0d: hd=%0d err=%0b", tag, got, hd, err);
        got++;
      end
      step();
      iter++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (got != n) begin n_fail++; $display("FAIL %s_timeout: got %0d results want %0d", tag, got, n); end
    if (!random_flow) begin
      n_checks++; if (iter != n + 2) begin n_fail++; $display("FAIL %s_throughput: got %0d cycles want %0d", tag, iter, n + 2); end
    end
    n_checks++; if (sample_cnt !== 32'(n)) begin n_fail++; $display("FAIL %s_sample_cnt: got %0d want %0d", tag, sample_cnt, n); end
    n_checks++; if (err_cnt !== 32'(errs)) begin n_fail++; $display("FAIL %s_err_cnt: got %0d want %0d", tag, err_cnt, errs); end
    n_checks++; if (max_hd !== exp_max(mx)) begin n_fail++; $display("FAIL %s_max_hd: got %0d want %0d", tag, max_hd, exp_max(mx)); end
  endtask

  task automatic test_saturate();
    pulse_clear();
    a = 16'h0000; b = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 20; i++) step();
    in_valid = 1'b0;
    step(); step();
    n_checks++; if (sample_cnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_sample_cnt4: got %0d want 15", sample_cnt4); end
    n_checks++; if (err_cnt4 !== 4'd15) begin n_fail++; $display("FAIL sat_err_cnt4: got %0d want 15", err_cnt4); end
    n_checks++; if (sample_cnt !== 32'd20) begin n_fail++; $display("FAIL sat_sample_cnt: got %0d want 20", sample_cnt); end
    n_checks++; if (err_cnt !== 32'd20) begin n_fail++; $display("FAIL sat_err_cnt: got %0d want 20", err_cnt); end
    n_checks++; if (max_hd !== exp_max(5'd16)) begin n_fail++; $display("FAIL sat_max_hd: got %0d want %0d", max_hd, exp_max(5'd16)); end
    $display("saturate: cnt4=%0d/%0d cnt=%0d/%0d max_hd=%0d", sample_cnt4, err_cnt4, sample_cnt, err_cnt, max_hd);
  endtask

  task automatic test_clear_collision();
    a = 16'h0000; b = 16'h01FF; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b1 || hd !== 5'd9) begin n_fail++; $display("FAIL clr_presented: got v=%0b hd=%0d want v=1 hd=9", out_valid, hd); end
    clear = 1'b1;
    step();
    clear = 1'b0;
    n_checks++; if (sample_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_sample_cnt: got %0d want 0", sample_cnt); end
    n_checks++; if (err_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_err_cnt: got %0d want 0", err_cnt); end
    n_checks++; if (max_hd !== 5'd0) begin n_fail++; $display("FAIL clr_max_hd: got %0d want 0", max_hd); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL clr_consumed: got %0b want 0", out_valid); end
    step();
    n_checks++; if (sample_cnt !== 32'd0) begin n_fail++; $display("FAIL clr_after: got %0d want 0", sample_cnt); end
    $display("clear collision: sample_cnt=%0d err_cnt=%0d max_hd=%0d", sample_cnt, err_cnt, max_hd);
  endtask

  task automatic test_reset_midstream();
    a = 16'h0000; b = 16'hFFFF; in_valid = 1'b1; out_ready = 1'b1;
    step(); step();
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_inflight: got %0b want 1", out_valid); end
    rst = 1'b1; in_valid = 1'b0;
    step();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    n_checks++; if (sample_cnt !== 32'd0 || err_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_counts: got %0d/%0d want 0/0", sample_cnt, err_cnt); end
    n_checks++; if (hd !== 5'd0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_hd_ready: got hd=%0d rdy=%0b want hd=0 rdy=1", hd, in_ready); end
    rst = 1'b0;
    step(); step(); step();
    n_checks++; if (out_valid !== 1'b0 || sample_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_discard: got v=%0b cnt=%0d want v=0 cnt=0", out_valid, sample_cnt); end
    n_checks++; if (max_hd !== 5'd0) begin n_fail++; $display("FAIL rst_max_hd: got %0d want 0", max_hd); end
    $display("reset midstream: out_valid=%0b sample_cnt=%0d max_hd=%0d", out_valid, sample_cnt, max_hd);
  endtask

  initial begin
    test_reset();
    test_vectors();
    run_stream(100, 1'b0, "stream");
    run_stream(40, 1'b1, "stall");
    test_saturate();
    test_clear_collision();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
